transmitter: RTL and testbench

UART transmitter that serialises bytes onto `Tx` in 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit). It is the outgoing counterpart of the existing UART receiver and shares the same 16x oversample enable `clken`: every bit is held for exactly 16 `clken` pulses. A small input FIFO lets the downsampling datapath push pixels in bursts without waiting for each frame to finish.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/transmitter.sv | 129 ++++++++++++
 tb/tb_transmitter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int OVERSAMPLE    = 16;
    localparam int DATA_BITS     = 8;
    localparam int BIT_LAST_TICK = 15;
    localparam int BIT_W         = $clog2(DATA_BITS);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head word. Writes while full are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;
    assign dout_o  = mem_q[rptr_q];

    always_ff @(posedge clk_50m) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/transmitter.sv
// 8N1 UART transmitter on the shared 16x clken, fed from a small byte FIFO.
module transmitter
    import uart_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       clken,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       Tx
);

    localparam int TICK_W = $clog2(OVERSAMPLE);

    uart_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_pos_q, bit_pos_d, next_pos;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q;
    logic              pop;
    logic              last_tick;
    logic [7:0]        fifo_head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .push_i  (wr_en),
        .din_i   (din),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .full    (full),
        .empty   (empty)
    );

    assign last_tick = (tick_q == TICK_W'(BIT_LAST_TICK));
    assign next_pos  = bit_pos_q + 1'b1;
    assign busy      = (state_q != IDLE);
    assign overflow  = overflow_q;
    assign Tx        = tx_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_pos_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_pos_q <= bit_pos_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            if (wr_en && full) overflow_q <= 1'b1;
        end
    end

    // Tick counts freely while busy and wraps 15->0 at each bit boundary.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_pos_d = bit_pos_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        if (clken) begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = 1'b0;
                        tick_d  = '0;
                        state_d = START;
                    end
                end
                START: begin
                    tick_d = tick_q + 1'b1;
                    if (last_tick) begin
                        bit_pos_d = '0;
                        tx_d      = shift_q[0];
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    tick_d = tick_q + 1'b1;
                    if (last_tick) begin
                        if (bit_pos_q == BIT_W'(DATA_BITS-1)) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            bit_pos_d = next_pos;
                            tx_d      = shift_q[next_pos];
                        end
                    end
                end
                STOP: begin
                    tick_d = tick_q + 1'b1;
                    if (last_tick) begin
                        // Chain straight into the next start bit when data is waiting.
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_head;
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for the UART transmitter: framing, FIFO limits, clken stalls, reset.
module tb_transmitter;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b1;
    logic       clken   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       full, empty, busy, overflow, Tx;

    int checks   = 0;
    int failures = 0;

    logic [9:0] s;
    logic       st;
    logic       bad;

    transmitter #(
        .DEPTH      (4),
        .OVERSAMPLE (16)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .clken    (clken),
        .din      (din),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow),
        .Tx       (Tx)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; inputs change 1ns after the edge and outputs are sampled there.
    task automatic cyc(input logic ce);
        clken = ce;
        @(posedge clk_50m);
        #1;
        clken = 1'b0;
    endtask

    // clken on every 4th cycle.
    task automatic pulses(input int n);
        repeat (n) begin
            cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
        end
    endtask

    task automatic write(input logic [7:0] b);
        wr_en = 1'b1;
        din   = b;
        cyc(1'b0);
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        rst_n = 1'b1;
        cyc(1'b0);
    endtask

    // Called right after the edge that drove the start bit; samples each bit
    // level and requires it to hold for exactly 16 pulses.
    task automatic rx_frame(output logic [9:0] seq, output logic stable);
        stable = 1'b1;
        seq    = '0;
        for (int b = 0; b < 10; b++) begin
            seq[b] = Tx;
            repeat (15) begin
                pulses(1);
                if (Tx !== seq[b]) stable = 1'b0;
            end
            pulses(1);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] b);
        logic [9:0] fs;
        logic       fst;
        rx_frame(fs, fst);
        chk({tag, " frame"}, 32'(fs), 32'({1'b1, b, 1'b0}));
        chk({tag, " stable"}, 32'(fst), 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3;
        chk("rst Tx", Tx, 1);
        chk("rst busy", busy, 0);
        chk("rst full", full, 0);
        chk("rst empty", empty, 1);
        chk("rst overflow", overflow, 0);
        cyc(1'b0); cyc(1'b0);
        rst_n = 1'b1;
        cyc(1'b0);

        // Single byte 0xA5
        write(8'hA5);
        chk("a5 empty after write", empty, 0);
        chk("a5 Tx before clken", Tx, 1);
        pulses(1);
        chk("a5 Tx start", Tx, 0);
        chk("a5 busy", busy, 1);
        chk("a5 popped", empty, 1);
        rx_frame(s, st);
        chk("a5 sequence", 32'(s), 32'(10'b1101001010));
        chk("a5 stable", st, 1);
        chk("a5 busy done", busy, 0);
        chk("a5 empty done", empty, 1);
        chk("a5 Tx idle", Tx, 1);

        // Back-to-back bytes decoded at the line
        write(8'h00); write(8'hFF); write(8'h3C);
        pulses(1);
        expect_frame("lb 00", 8'h00);
        expect_frame("lb FF", 8'hFF);
        expect_frame("lb 3C", 8'h3C);
        chk("lb idle", busy, 0);

        // Burst of 5 into a 4-deep FIFO
        write(8'h01); write(8'h02); write(8'h03); write(8'h04);
        chk("burst full", full, 1);
        chk("burst no overflow yet", overflow, 0);
        write(8'h05);
        chk("burst overflow", overflow, 1);
        chk("burst still full", full, 1);
        pulses(1);
        expect_frame("burst 01", 8'h01);
        expect_frame("burst 02", 8'h02);
        expect_frame("burst 03", 8'h03);
        expect_frame("burst 04", 8'h04);
        chk("burst idle", busy, 0);
        chk("burst empty", empty, 1);
        bad = 1'b0;
        repeat (40) begin
            pulses(1);
            if (Tx !== 1'b1) bad = 1'b1;
        end
        chk("burst 5th dropped", bad, 0);

        // Write while full on the edge where STOP pops
        do_reset();
        chk("wf overflow cleared", overflow, 0);
        write(8'h11);
        pulses(1);
        chk("wf start", Tx, 0);
        write(8'h21); write(8'h22); write(8'h23); write(8'h24);
        chk("wf full", full, 1);
        pulses(159);
        cyc(1'b0); cyc(1'b0); cyc(1'b0);
        wr_en = 1'b1;
        din   = 8'h77;
        cyc(1'b1);
        wr_en = 1'b0;
        chk("wf overflow", overflow, 1);
        chk("wf occupancy 3", full, 0);
        chk("wf next start", Tx, 0);
        chk("wf not empty", empty, 0);
        expect_frame("wf 21", 8'h21);
        expect_frame("wf 22", 8'h22);
        expect_frame("wf 23", 8'h23);
        expect_frame("wf 24", 8'h24);
        chk("wf idle", busy, 0);

        // clken stall in the middle of data bit 2 of 0x96
        write(8'h96);
        pulses(1);
        pulses(53);
        chk("stall pre", Tx, 1);
        bad = 1'b0;
        repeat (100) begin
            cyc(1'b0);
            if (Tx !== 1'b1) bad = 1'b1;
        end
        chk("stall hold", bad, 0);
        pulses(10);
        chk("stall bit2 tail", Tx, 1);
        pulses(1);
        chk("stall bit3", Tx, 0);
        pulses(16);
        chk("stall bit4", Tx, 1);
        pulses(64);
        chk("stall stop Tx", Tx, 1);
        chk("stall stop busy", busy, 1);
        pulses(15);
        chk("stall stop last", busy, 1);
        pulses(1);
        chk("stall idle", busy, 0);

        // Reset during data bit 3 of 0x55 with two bytes queued
        write(8'h55); write(8'h66); write(8'h77);
        pulses(1);
        pulses(72);
        chk("rm bit3", Tx, 0);
        chk("rm queued", empty, 0);
        rst_n = 1'b0;
        #2;
        chk("rm Tx", Tx, 1);
        chk("rm empty", empty, 1);
        chk("rm busy", busy, 0);
        chk("rm full", full, 0);
        cyc(1'b0); cyc(1'b0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (200) begin
            pulses(1);
            if (Tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        chk("rm silent", bad, 0);
        write(8'h5A);
        pulses(1);
        expect_frame("rm recover", 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
